// File: rtl/dshot_pkg.sv
// Shared definitions for the DShot supervisory path: state encoding,
// special command numbers and the internal throttle width.
package dshot_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      ARMED    = 2'd2,
      FAILSAFE = 2'd3
   } arm_state_t;

   localparam logic [5:0] CMD_MOTOR_STOP    = 6'd0;
   localparam logic [5:0] CMD_SPIN_NORMAL   = 6'd20;
   localparam logic [5:0] CMD_SPIN_REVERSED = 6'd21;

   localparam int THROTTLE_W = 11;

endpackage

// File: rtl/dshot_arming_controller_slew_limiter.sv
// Rise-limited, fall-immediate 11-bit speed register. Increases are paced
// by a free-running prescaler; decreases and forced stops act at once.
module slew_limiter
   import dshot_pkg::*;
#(
   parameter int SLEW_DIV  = 1200,
   parameter int SLEW_STEP = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [THROTTLE_W-1:0] target,
   input  logic                  force_zero,
   output logic [THROTTLE_W-1:0] speed
);

   localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
   localparam int SUM_W = THROTTLE_W + 1;

   logic [DIV_W-1:0] presc;
   logic             tick;
   logic [SUM_W-1:0] raised;
   logic [SUM_W-1:0] target_ext;

   // Tick on prescaler wrap; the raised value is one bit wider so it never wraps past 2047
   always_comb begin
      tick       = (presc == DIV_W'(SLEW_DIV - 1));
      raised     = {1'b0, speed} + SUM_W'(SLEW_STEP);
      target_ext = {1'b0, target};
   end

   // Free-running prescaler counting 0..SLEW_DIV-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + DIV_W'(1);
      end
   end

   // Speed follows target: stop and fall immediately, rise by at most one step per tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         speed <= '0;
      end else if (force_zero) begin
         speed <= '0;
      end else if (target < speed) begin
         speed <= target;
      end else if (tick && (speed < target)) begin
         speed <= (raised > target_ext) ? target : raised[THROTTLE_W-1:0];
      end
   end

endmodule

// File: rtl/dshot_arming_controller.sv
// Supervisory sequencer between the DShot frame decoder and the motor
// output: arm/disarm/failsafe FSM, link timeout, repeat-qualified spin
// direction commands and a slew-limited speed output.
module dshot_arming_controller
   import dshot_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1200000,
   parameter int ARM_FRAMES     = 10,
   parameter int CMD_REPEAT     = 6,
   parameter int SLEW_DIV       = 1200,
   parameter int SLEW_STEP      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frameStrobe,
   input  logic [THROTTLE_W-1:0] setSpeed,
   input  logic                  isValidSpeed,
   input  logic                  isSpecialCommand,
   input  logic [5:0]            specialCommand,
   input  logic                  CRCValid,
   output logic [7:0]            motorSpeed,
   output logic                  armed,
   output logic                  failsafe,
   output logic                  reversed,
   output logic [1:0]            state
);

   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int ARM_W = $clog2(ARM_FRAMES + 1);
   localparam int REP_W = $clog2(CMD_REPEAT + 1);

   arm_state_t            cur_state;
   logic [ARM_W-1:0]      arm_cnt;
   logic [TO_W-1:0]       timeout_cnt;
   logic [REP_W-1:0]      rep_cnt;
   logic [REP_W-1:0]      rep_next;
   logic [5:0]            last_cmd;
   logic [THROTTLE_W-1:0] target;
   logic [THROTTLE_W-1:0] speed;

   logic accepted;
   logic zero_frame;
   logic nonzero_frame;
   logic dir_cmd;
   logic timeout_hit;
   logic kill_speed;

   // Frame classification; a CRC-failed frame is treated as if it never arrived
   always_comb begin
      accepted      = frameStrobe && CRCValid;
      zero_frame    = accepted &&
                      ((isSpecialCommand && (specialCommand == CMD_MOTOR_STOP)) ||
                       (isValidSpeed && (setSpeed == '0)));
      nonzero_frame = accepted && isValidSpeed && (setSpeed != '0);
      dir_cmd       = accepted && isSpecialCommand &&
                      ((specialCommand == CMD_SPIN_NORMAL) ||
                       (specialCommand == CMD_SPIN_REVERSED));
      timeout_hit   = (timeout_cnt == TO_W'(TIMEOUT_CYCLES));
      kill_speed    = (cur_state == ARMED) && timeout_hit && !accepted;
      rep_next      = (specialCommand == last_cmd) ? (rep_cnt + REP_W'(1)) : REP_W'(1);
   end

   // Link timeout: cleared by any accepted frame, otherwise counts up and saturates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_cnt <= '0;
      end else if (accepted) begin
         timeout_cnt <= '0;
      end else if (!timeout_hit) begin
         timeout_cnt <= timeout_cnt + TO_W'(1);
      end
   end

   // Arming FSM with registered armed/failsafe flags and the throttle target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= DISARMED;
         arm_cnt   <= '0;
         target    <= '0;
         armed     <= 1'b0;
         failsafe  <= 1'b0;
      end else begin
         case (cur_state)
            DISARMED: begin
               if (zero_frame) begin
                  if (ARM_FRAMES <= 1) begin
                     cur_state <= ARMED;
                     armed     <= 1'b1;
                  end else begin
                     cur_state <= ARMING;
                     arm_cnt   <= ARM_W'(1);
                  end
               end
            end
            ARMING: begin
               if (zero_frame) begin
                  if ((int'(arm_cnt) + 1) >= ARM_FRAMES) begin
                     cur_state <= ARMED;
                     armed     <= 1'b1;
                     arm_cnt   <= '0;
                  end else begin
                     arm_cnt <= arm_cnt + ARM_W'(1);
                  end
               end else if (nonzero_frame) begin
                  cur_state <= DISARMED;
                  arm_cnt   <= '0;
               end else if (timeout_hit && !accepted) begin
                  cur_state <= FAILSAFE;
                  failsafe  <= 1'b1;
                  arm_cnt   <= '0;
               end
            end
            ARMED: begin
               if (nonzero_frame) begin
                  target <= setSpeed;
               end else if (zero_frame) begin
                  target <= '0;
               end else if (kill_speed) begin
                  cur_state <= FAILSAFE;
                  armed     <= 1'b0;
                  failsafe  <= 1'b1;
                  target    <= '0;
               end
            end
            FAILSAFE: begin
               target <= '0;
               if (zero_frame) begin
                  failsafe <= 1'b0;
                  if (ARM_FRAMES <= 1) begin
                     cur_state <= ARMED;
                     armed     <= 1'b1;
                  end else begin
                     cur_state <= ARMING;
                     arm_cnt   <= ARM_W'(1);
                  end
               end
            end
            default: begin
               cur_state <= DISARMED;
               arm_cnt   <= '0;
               target    <= '0;
               armed     <= 1'b0;
               failsafe  <= 1'b0;
            end
         endcase
      end
   end

   // Spin direction: applied only after CMD_REPEAT identical commands and only while stopped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt  <= '0;
         last_cmd <= CMD_MOTOR_STOP;
         reversed <= 1'b0;
      end else if (dir_cmd) begin
         last_cmd <= specialCommand;
         if (rep_next == REP_W'(CMD_REPEAT)) begin
            rep_cnt <= '0;
            if (speed == '0) begin
               reversed <= (specialCommand == CMD_SPIN_REVERSED);
            end
         end else begin
            rep_cnt <= rep_next;
         end
      end else if (accepted) begin
         rep_cnt <= '0;
      end
   end

   slew_limiter #(
      .SLEW_DIV  (SLEW_DIV),
      .SLEW_STEP (SLEW_STEP)
   ) u_slew (
      .clk        (clk),
      .rst        (rst),
      .target     (target),
      .force_zero (kill_speed),
      .speed      (speed)
   );

   assign motorSpeed = speed[THROTTLE_W-1:3];
   assign state      = cur_state;

endmodule

// File: tb/tb_dshot_arming_controller.sv
// Self-checking bench for dshot_arming_controller: a vector table for the
// arming and direction logic plus hand sequences for ramps, timeout and reset.
module tb_dshot_arming_controller;

   logic        clk;
   logic        rst;
   logic        frameStrobe;
   logic [10:0] setSpeed;
   logic        isValidSpeed;
   logic        isSpecialCommand;
   logic [5:0]  specialCommand;
   logic        CRCValid;
   logic [7:0]  motorSpeed;
   logic        armed;
   logic        failsafe;
   logic        reversed;
   logic [1:0]  state;

   typedef struct {
      logic        strobe;
      logic        crc;
      logic        valid;
      logic [10:0] speed;
      logic        special;
      logic [5:0]  cmd;
      logic        chk;
      logic [1:0]  st;
      logic        rev;
      logic        chk_ms;
      logic [7:0]  ms;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   step_idx = 0;

   dshot_arming_controller #(
      .TIMEOUT_CYCLES (100),
      .ARM_FRAMES     (3),
      .CMD_REPEAT     (6),
      .SLEW_DIV       (4),
      .SLEW_STEP      (16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .frameStrobe      (frameStrobe),
      .setSpeed         (setSpeed),
      .isValidSpeed     (isValidSpeed),
      .isSpecialCommand (isSpecialCommand),
      .specialCommand   (specialCommand),
      .CRCValid         (CRCValid),
      .motorSpeed       (motorSpeed),
      .armed            (armed),
      .failsafe         (failsafe),
      .reversed         (reversed),
      .state            (state)
   );

   // 100 MHz-style free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the run stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic compare(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit s, input bit c, input bit v, input int sp,
                               input bit sc, input int cmd, input int st,
                               input int rev, input int ms);
      vec_t r;
      r.strobe  = s;
      r.crc     = c;
      r.valid   = v;
      r.speed   = sp[10:0];
      r.special = sc;
      r.cmd     = cmd[5:0];
      r.chk     = (st >= 0);
      r.st      = st[1:0];
      r.rev     = rev[0];
      r.chk_ms  = (ms >= 0);
      r.ms      = ms[7:0];
      return r;
   endfunction

   function automatic vec_t thr(input int sp, input int st, input int rev, input int ms);
      return mk(1'b1, 1'b1, 1'b1, sp, 1'b0, 0, st, rev, ms);
   endfunction

   function automatic vec_t cmdf(input int c, input int st, input int rev, input int ms);
      return mk(1'b1, 1'b1, 1'b0, 0, 1'b1, c, st, rev, ms);
   endfunction

   function automatic vec_t idl(input int st, input int rev, input int ms);
      return mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, st, rev, ms);
   endfunction

   function automatic vec_t bad(input int sp, input int st, input int rev, input int ms);
      return mk(1'b1, 1'b0, 1'b1, sp, 1'b0, 0, st, rev, ms);
   endfunction

   // Drive one cycle of decoder outputs and queue what the DUT must show after the edge
   task automatic applyStimulus(input vec_t v);
      frameStrobe      = v.strobe;
      CRCValid         = v.crc;
      isValidSpeed     = v.valid;
      setSpeed         = v.speed;
      isSpecialCommand = v.special;
      specialCommand   = v.cmd;
      exp_q.push_back(v);
      @(negedge clk);
      frameStrobe = 1'b0;
   endtask

   // Pop the oldest expectation and compare it against the settled outputs
   task automatic checkOutput();
      vec_t e;
      step_idx++;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL scoreboard step %0d: got empty queue, expected an entry", step_idx);
         return;
      end
      e = exp_q.pop_front();
      if (e.chk) begin
         compare($sformatf("v%0d.state", step_idx), int'(state), int'(e.st));
         compare($sformatf("v%0d.armed", step_idx), int'(armed), int'(e.st == 2'd2));
         compare($sformatf("v%0d.failsafe", step_idx), int'(failsafe), int'(e.st == 2'd3));
         compare($sformatf("v%0d.reversed", step_idx), int'(reversed), int'(e.rev));
         if (e.chk_ms) begin
            compare($sformatf("v%0d.motorSpeed", step_idx), int'(motorSpeed), int'(e.ms));
         end
      end
   endtask

   task automatic step(input vec_t v);
      applyStimulus(v);
      checkOutput();
   endtask

   // Stream throttle frames until motorSpeed hits goal, watching the rise rate
   task automatic ramp_until(input int sp, input int goal, input int max_cycles,
                             output int cycles, output bit reached, output bit bad_rate);
      int prev;
      int cur;
      int last_change;
      prev        = int'(motorSpeed);
      last_change = -1;
      reached     = 1'b0;
      bad_rate    = 1'b0;
      cycles      = 0;
      while (!reached && (cycles < max_cycles)) begin
         step(thr(sp, -1, 0, -1));
         cycles++;
         cur = int'(motorSpeed);
         if (cur != prev) begin
            if ((cur < prev) || (cur > prev + 2)) bad_rate = 1'b1;
            if ((last_change >= 0) && (cycles - last_change < 4)) bad_rate = 1'b1;
            last_change = cycles;
         end
         prev = cur;
         if (cur == goal) reached = 1'b1;
      end
   endtask

   initial begin
      int  cyc;
      bit  ok;
      bit  bad_rate;

      rst              = 1'b1;
      frameStrobe      = 1'b0;
      setSpeed         = '0;
      isValidSpeed     = 1'b0;
      isSpecialCommand = 1'b0;
      specialCommand   = '0;
      CRCValid         = 1'b0;

      repeat (3) @(negedge clk);
      compare("reset.motorSpeed", int'(motorSpeed), 0);
      compare("reset.armed", int'(armed), 0);
      compare("reset.failsafe", int'(failsafe), 0);
      compare("reset.reversed", int'(reversed), 0);
      compare("reset.state", int'(state), 0);
      rst = 1'b0;

      // Arming sequence with a restart, then repeat-qualified direction commands at speed 0
      tbl.push_back(thr(700, 0, 0, 0));
      tbl.push_back(cmdf(21, 0, 0, 0));
      tbl.push_back(thr(0, 1, 0, 0));
      tbl.push_back(thr(0, 1, 0, 0));
      tbl.push_back(thr(500, 0, 0, 0));
      tbl.push_back(bad(0, 0, 0, 0));
      tbl.push_back(cmdf(0, 1, 0, 0));
      tbl.push_back(cmdf(5, 1, 0, 0));
      tbl.push_back(thr(0, 1, 0, 0));
      tbl.push_back(thr(0, 2, 0, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(cmdf(21, 2, 0, 0));
      tbl.push_back(cmdf(21, 2, 1, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(cmdf(20, 2, 1, 0));
      tbl.push_back(thr(0, 2, 1, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(cmdf(20, 2, 1, 0));
      tbl.push_back(cmdf(20, 2, 0, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(cmdf(21, 2, 0, 0));
      tbl.push_back(cmdf(20, 2, 0, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(cmdf(21, 2, 0, 0));
      tbl.push_back(cmdf(21, 2, 1, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(cmdf(20, 2, 1, 0));
      tbl.push_back(cmdf(20, 2, 0, 0));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Ramp 0 -> 1024: 64 ticks of 16, one tick per 4 cycles
      ramp_until(1024, 128, 300, cyc, ok, bad_rate);
      compare("ramp1024.reached", int'(ok), 1);
      compare("ramp1024.cycles_in_window", int'((cyc >= 253) && (cyc <= 258)), 1);
      compare("ramp1024.rise_rate_ok", int'(bad_rate), 0);
      for (int i = 0; i < 6; i++) step(thr(1024, 2, 0, 128));

      // Decreases land one cycle after the target register updates
      step(thr(400, 2, 0, 128));
      step(thr(400, 2, 0, 50));

      // Direction request while spinning is dropped
      ramp_until(800, 100, 150, cyc, ok, bad_rate);
      compare("ramp800.reached", int'(ok), 1);
      compare("ramp800.rise_rate_ok", int'(bad_rate), 0);
      for (int i = 0; i < 6; i++) step(cmdf(21, 2, 0, 100));

      // Full speed, then link loss: failsafe exactly on the 101st silent cycle
      ramp_until(2047, 255, 400, cyc, ok, bad_rate);
      compare("ramp2047.reached", int'(ok), 1);
      compare("ramp2047.rise_rate_ok", int'(bad_rate), 0);
      for (int i = 0; i < 100; i++) step(idl(2, 0, 255));
      step(idl(3, 0, 0));
      step(thr(1000, 3, 0, 0));
      step(thr(0, 1, 0, 0));
      step(thr(0, 1, 0, 0));
      step(thr(0, 2, 0, 0));

      // A frame on the exact timeout cycle wins; a CRC-bad frame does not feed the watchdog
      for (int i = 0; i < 100; i++) step(idl(2, 0, 0));
      step(thr(300, 2, 0, 0));
      for (int i = 0; i < 50; i++) step(idl(2, 0, -1));
      step(bad(300, 2, 0, -1));
      for (int i = 0; i < 49; i++) step(idl(2, 0, -1));
      step(idl(3, 0, 0));
      step(thr(0, 1, 0, 0));
      step(thr(0, 1, 0, 0));
      step(thr(0, 2, 0, 0));
      for (int i = 0; i < 5; i++) step(cmdf(21, 2, 0, 0));
      step(cmdf(21, 2, 1, 0));

      // Asynchronous reset in the middle of a ramp
      ramp_until(1600, 50, 200, cyc, ok, bad_rate);
      compare("ramp1600.reached", int'(ok), 1);
      #2 rst = 1'b1;
      #1;
      compare("async_rst.motorSpeed", int'(motorSpeed), 0);
      compare("async_rst.armed", int'(armed), 0);
      compare("async_rst.failsafe", int'(failsafe), 0);
      compare("async_rst.reversed", int'(reversed), 0);
      compare("async_rst.state", int'(state), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(idl(0, 0, 0));
      step(thr(0, 1, 0, 0));
      step(thr(0, 1, 0, 0));
      step(thr(0, 2, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
